fan_speed_scheduler: RTL
========================

FAN_SPEED_SCHEDULER -- requirements
Module: fan_speed_scheduler

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter RAMP_MS, default 10, milliseconds per 1 % duty step.
REQ-003 SHALL have parameter DIST_FAR, default 12'h020; distance at or above this value means no user is present.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port reset_p, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port btn_pe, input, 1, one-cycle pulse that advances the speed level.
REQ-007 SHALL have port timer_pe, input, 1, one-cycle pulse that advances the off-timer preset.
REQ-008 SHALL have port motor_off, input, 1, level-sensitive forced stop.
REQ-009 SHALL have ports remote_valid (input, 1), remote_level (input, 2) and remote_ready (output, 1), the remote speed-request handshake.
REQ-010 SHALL have ports distance (input, 12) and distance_valid (input, 1), the ultrasonic measurement and its qualifier.
REQ-011 SHALL have port duty_o, output, 7, current PWM duty in percent (0–100).
REQ-012 SHALL have ports level_o (output, 2), motor_en_o (output, 1) and motor_led_o (output, 3), giving the target level, the driver enable and the one-hot level LED.
REQ-013 SHALL have ports timer_led_o (output, 2) and paused_o (output, 1), giving the timer preset index and the absence-pause flag.

Function
REQ-014 SHALL map level to target duty as follows: 0 → 0, 1 → 25, 2 → 45, 3 → 100.
REQ-015 SHALL apply level-change sources by priority, highest first: motor_off, timer expiry, accepted remote request, btn_pe.
- A lower-priority source in the same cycle is ignored.
REQ-016 SHALL wrap btn_pe from level 3 to 0.
- An accepted remote request loads remote_level directly.
REQ-017 SHALL drive remote_ready high unless motor_off is high or the timer expires in that cycle.
- A request is accepted when remote_valid and remote_ready are both high.
- An accepted request whose level equals the current level has no effect.
REQ-018 SHALL implement the FSM states OFF, RAMP, RUN and PAUSE.
REQ-019 SHALL transition from OFF to RAMP when level becomes nonzero.
REQ-020 SHALL transition from RAMP to RUN when duty_o equals the target.
REQ-021 SHALL transition from RUN to RAMP on any level change.
REQ-022 SHALL transition from RAMP to OFF when level is 0 and duty_o is 0.
REQ-023 SHALL enter PAUSE from RUN or RAMP when distance_valid is high with distance >= DIST_FAR while level is nonzero.
- On entering PAUSE, duty_o = 0 and motor_en_o = 0 in the next cycle.
- The level is retained.
REQ-024 SHALL leave PAUSE to RAMP, ramping from 0, when distance_valid is high with distance < DIST_FAR.
- Level changes are accepted in PAUSE and update the retained level.
- If the level becomes 0 in PAUSE, the FSM goes to OFF.
REQ-025 SHALL generate a 1 ms tick from clk (CLK_HZ/1000 cycles).
- In RAMP, duty_o moves 1 % toward the target every RAMP_MS ticks.
- duty_o never overshoots the target.
REQ-026 SHALL hold motor_en_o high whenever duty_o is nonzero.
REQ-027 SHALL drive motor_led_o as one-hot level-1 (bit index = level − 1), or 000 when level is 0.
REQ-028 SHALL cycle timer_pe through the presets 0 (disabled), 1, 3, 5 minutes, shown on timer_led_o as index 0–3.
REQ-029 SHALL load the selected preset into a seconds down-counter on each timer_pe and count it down on 1 s boundaries.
- Reaching 0 from a nonzero preset is a timer expiry: level → 0 and timer_led_o → 0.
- The countdown continues during PAUSE.
REQ-030 SHALL cancel the countdown and set timer_led_o to 0 when motor_off is asserted or the level returns to 0 by any source.

Reset
REQ-031 SHALL on reset_p set: state OFF, level 0, duty_o 0, motor_en_o 0, motor_led_o 000, timer_led_o 0, paused_o 0, remote_ready 0, all counters 0.
REQ-032 SHALL immediately zero all outputs when reset is asserted mid-ramp, with no ramp-down.

Configuration
REQ-033 SHALL compile soft start in when FAN_SOFT_START_EN is defined: ramping per REQ-025.
REQ-034 SHALL, when FAN_SOFT_START_EN is undefined:
- load duty_o with the target one cycle after a level change;
- never enter RAMP (OFF/PAUSE ↔ RUN directly);
- omit the ramp counter.

Structure
REQ-035 SHALL place in a shared package: the state enum, the level-to-duty constants (25/45/100), the timer preset table (0/60/180/300 s) and the default DIST_FAR.
REQ-036 SHALL implement the ms/second tick generation as sub-module fan_tick_gen, outputting tick_ms and tick_s.

Verification (CLK_HZ=10_000, RAMP_MS=1, FAN_SOFT_START_EN defined unless stated)
REQ-037 SHALL verify button ramp: one btn_pe from OFF → level_o=1, duty_o climbs 0→25 one step per ms, state RUN after 25 ms, motor_led_o=001.
REQ-038 SHALL verify priority: btn_pe and remote_valid with remote_level=3 in the same cycle → level_o=3 and btn_pe ignored; with motor_off also high → remote_ready=0 and level_o=0.
REQ-039 SHALL verify pause: in RUN at level 2, distance=12'h030 with valid → duty_o=0 next cycle, paused_o=1, level_o=2; distance=12'h010 with valid → ramp 0→45.
REQ-040 SHALL verify the timer: level 1, timer_pe once (1 min) → after 60 s level_o=0, duty_o ramps to 0, timer_led_o=0, state OFF.
REQ-041 SHALL verify wrap and no soft start: with the macro undefined, four btn_pe pulses → duty_o 25, 45, 100, 0, each one cycle after its pulse.
REQ-042 SHALL verify reset mid-ramp: reset_p at duty_o=12 → all outputs 0 immediately; after release, state OFF.

Source files
------------

// File: rtl/fan_speed_scheduler_pkg.sv
// Shared definitions for the fan speed scheduler.
//   fan_state_t    : controller FSM state encoding (also exported for debug)
//   DUTY_L1..L3    : target PWM duty (percent) for speed levels 1..3
//   TIMER_S1..S3   : off-timer presets in seconds for timer indices 1..3
//   DIST_FAR_DEFAULT : distance at/above which nobody is considered present
//   level_duty()   : speed level -> target duty
//   timer_preset() : timer index -> preset seconds (index 0 = disabled)
package fan_speed_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_RAMP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_PAUSE = 2'd3
  } fan_state_t;

  localparam logic [6:0] DUTY_L1 = 7'd25;
  localparam logic [6:0] DUTY_L2 = 7'd45;
  localparam logic [6:0] DUTY_L3 = 7'd100;

  localparam int TIMER_W = 9;
  localparam logic [TIMER_W-1:0] TIMER_S1 = 9'd60;
  localparam logic [TIMER_W-1:0] TIMER_S2 = 9'd180;
  localparam logic [TIMER_W-1:0] TIMER_S3 = 9'd300;

  localparam logic [11:0] DIST_FAR_DEFAULT = 12'h020;

  function automatic logic [6:0] level_duty(input logic [1:0] lvl);
    case (lvl)
      2'd1:    return DUTY_L1;
      2'd2:    return DUTY_L2;
      2'd3:    return DUTY_L3;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [TIMER_W-1:0] timer_preset(input logic [1:0] idx);
    case (idx)
      2'd1:    return TIMER_S1;
      2'd2:    return TIMER_S2;
      2'd3:    return TIMER_S3;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/fan_tick_gen.sv
// Millisecond and second tick generator.
//   clk, reset_p : clock, asynchronous active-high reset
//   tick_ms      : one-cycle pulse every CLK_HZ/1000 cycles
//   tick_s       : one-cycle pulse on every 1000th tick_ms (coincides with it)
module fan_tick_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset_p,
  output logic tick_ms,
  output logic tick_s
);

  // Clocks slower than 1 kHz degenerate to a tick every cycle.
  localparam int unsigned MS_CYCLES = (CLK_HZ >= 1000) ? (CLK_HZ / 1000) : 1;
  localparam int CW = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;

  logic [CW-1:0] cyc_cnt;
  logic [9:0]    ms_cnt;

  assign tick_ms = (cyc_cnt == CW'(MS_CYCLES - 1));
  assign tick_s  = tick_ms && (ms_cnt == 10'd999);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cyc_cnt <= '0;
      ms_cnt  <= '0;
    end else if (tick_ms) begin
      cyc_cnt <= '0;
      ms_cnt  <= (ms_cnt == 10'd999) ? 10'd0 : ms_cnt + 10'd1;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fan_speed_scheduler.sv
// Fan speed scheduler: speed level selection (button, remote, off-timer,
// forced stop), presence-based pause and PWM duty generation.
// Build option: define FAN_SOFT_START_EN to ramp duty 1 % per RAMP_MS ms;
// without it duty jumps to the target one cycle after a level change and
// the RAMP state is never used.
// Ports:
//   clk, reset_p        : clock, asynchronous active-high reset
//   btn_pe, timer_pe    : one-cycle pulses advancing level / timer preset
//   motor_off           : level-sensitive forced stop
//   remote_valid/level/ready : remote speed request handshake
//   distance, distance_valid : ultrasonic measurement and qualifier
//   duty_o, level_o, motor_en_o, motor_led_o, timer_led_o, paused_o : status
//   fsm_state           : current controller state (debug)
module fan_speed_scheduler
  import fan_speed_scheduler_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned RAMP_MS  = 10,
  parameter logic [11:0] DIST_FAR = DIST_FAR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        btn_pe,
  input  logic        timer_pe,
  input  logic        motor_off,
  input  logic        remote_valid,
  input  logic [1:0]  remote_level,
  output logic        remote_ready,
  input  logic [11:0] distance,
  input  logic        distance_valid,
  output logic [6:0]  duty_o,
  output logic [1:0]  level_o,
  output logic        motor_en_o,
  output logic [2:0]  motor_led_o,
  output logic [1:0]  timer_led_o,
  output logic        paused_o,
  output fan_state_t  fsm_state
);

  fan_state_t         state, state_nxt;
  logic [1:0]         level, level_nxt;
  logic [6:0]         duty, duty_nxt, target;
  logic [1:0]         timer_idx;
  logic [TIMER_W-1:0] sec_cnt;
  logic               ready_en;
  logic               tick_ms, tick_s;
  logic               timer_expire, timer_cancel, remote_acc, far, near;

  fan_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk     (clk),
    .reset_p (reset_p),
    .tick_ms (tick_ms),
    .tick_s  (tick_s)
  );

  // Remote handshake: remote_ready is offered every cycle out of reset except
  // when a higher-priority source (motor_off, timer expiry) owns the level;
  // a request is consumed in the cycle where remote_valid && remote_ready.
  assign timer_expire = tick_s && (sec_cnt == 9'd1);
  assign remote_ready = ready_en && !motor_off && !timer_expire;
  assign remote_acc   = remote_valid && remote_ready;

  always_comb begin
    level_nxt = level;
    if (motor_off || timer_expire) level_nxt = 2'd0;
    else if (remote_acc)           level_nxt = remote_level;
    else if (btn_pe)               level_nxt = level + 2'd1;
  end

  assign timer_cancel = motor_off || timer_expire ||
                        ((level != 2'd0) && (level_nxt == 2'd0));

  assign target = level_duty(level);
  assign far    = distance_valid && (distance >= DIST_FAR);
  assign near   = distance_valid && (distance <  DIST_FAR);

`ifdef FAN_SOFT_START_EN
  localparam int RW = (RAMP_MS > 1) ? $clog2(RAMP_MS) : 1;
  logic [RW-1:0] ramp_cnt;
  logic          ramp_step;

  assign ramp_step = (state == ST_RAMP) && tick_ms && (ramp_cnt == RW'(RAMP_MS - 1));

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p)               ramp_cnt <= '0;
    else if (state != ST_RAMP) ramp_cnt <= '0;
    else if (tick_ms)          ramp_cnt <= ramp_step ? '0 : ramp_cnt + 1'b1;
  end
`else
  // The millisecond tick and ramp rate only matter for soft start.
  logic unused_tick_ms;
  localparam int unsigned unused_ramp_ms = RAMP_MS;
  assign unused_tick_ms = tick_ms;
`endif

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    case (state)
`ifdef FAN_SOFT_START_EN
      ST_OFF:   if (level != 2'd0) state_nxt = ST_RAMP;
      ST_RAMP: begin
        if (far && level != 2'd0)               state_nxt = ST_PAUSE;
        else if (level == 2'd0 && duty == 7'd0) state_nxt = ST_OFF;
        else if (duty == target)                state_nxt = ST_RUN;
      end
      // A level change shows up as duty no longer matching the target.
      ST_RUN: begin
        if (far && level != 2'd0) state_nxt = ST_PAUSE;
        else if (duty != target)  state_nxt = ST_RAMP;
      end
      ST_PAUSE: begin
        if (level == 2'd0) state_nxt = ST_OFF;
        else if (near)     state_nxt = ST_RAMP;
      end
      default:  state_nxt = ST_OFF;
`else
      ST_OFF:   if (level != 2'd0) state_nxt = ST_RUN;
      ST_RUN: begin
        if (far && level != 2'd0) state_nxt = ST_PAUSE;
        else if (level == 2'd0)   state_nxt = ST_OFF;
      end
      ST_PAUSE: begin
        if (level == 2'd0) state_nxt = ST_OFF;
        else if (near)     state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_OFF;
`endif
    endcase

`ifdef FAN_SOFT_START_EN
    if (state_nxt == ST_PAUSE)          duty_nxt = 7'd0;
    else if (ramp_step && duty < target) duty_nxt = duty + 7'd1;
    else if (ramp_step && duty > target) duty_nxt = duty - 7'd1;
`else
    duty_nxt = (state_nxt == ST_PAUSE) ? 7'd0 : target;
`endif
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state    <= ST_OFF;
      level    <= 2'd0;
      duty     <= 7'd0;
      ready_en <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      duty     <= duty_nxt;
      ready_en <= 1'b1;
    end
  end

  // Off-timer: the countdown keeps running while paused; expiry is the
  // 1 -> 0 step, so a disabled preset (0) never expires.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      timer_idx <= 2'd0;
      sec_cnt   <= '0;
    end else if (timer_cancel) begin
      timer_idx <= 2'd0;
      sec_cnt   <= '0;
    end else if (timer_pe) begin
      timer_idx <= timer_idx + 2'd1;
      sec_cnt   <= timer_preset(timer_idx + 2'd1);
    end else if (tick_s && sec_cnt != '0) begin
      sec_cnt   <= sec_cnt - 9'd1;
    end
  end

  assign duty_o      = duty;
  assign level_o     = level;
  assign motor_en_o  = (duty != 7'd0);
  assign motor_led_o = (level == 2'd0) ? 3'b000 : (3'b001 << (level - 2'd1));
  assign timer_led_o = timer_idx;
  assign paused_o    = (state == ST_PAUSE);
  assign fsm_state   = state;

endmodule
